maze_position_datapath: RTL and testbench

Datapath partner of the maze game's position-control FSM. It receives that FSM's move and draw commands and returns its done and legality handshakes. It tracks the player's cell, checks whether a requested move is legal against the maze wall memory, commits legal moves, and sweeps the player box onto the VGA plot port in erase (background) or draw (player) colour.

---
 rtl/maze_pkg.sv | 17 +
 rtl/maze_position_datapath_if.sv | 33 +++
 rtl/box_sweeper.sv | 32 +++
 rtl/maze_position_datapath.sv | 120 ++++++++++++
 tb/tb_maze_position_datapath.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared encodings and grid defaults for the maze position datapath, control FSM and maze ROM.
package maze_pkg;
    localparam int DEF_GRID_W  = 40;
    localparam int DEF_GRID_H  = 30;
    localparam int DEF_BOX     = 4;
    localparam int DEF_START_X = 1;
    localparam int DEF_START_Y = 1;
    localparam int DEF_GOAL_X  = 38;
    localparam int DEF_GOAL_Y  = 28;
    localparam logic [2:0] DEF_BG_COLOUR     = 3'b111;
    localparam logic [2:0] DEF_PLAYER_COLOUR = 3'b100;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic [2:0] {IDLE, ERASE, CHECK_ADDR, CHECK_WAIT, CHECK_DONE, DRAW} state_t;
    function automatic dir_t encode_dir(input logic up, input logic down, input logic left, input logic right);
        return right ? RIGHT : left ? LEFT : down ? DOWN : UP;
    endfunction
endpackage

// File: rtl/maze_position_datapath_if.sv
// maze_position_datapath_if: controller, maze ROM and VGA signals of the position datapath.
// reachedGoal exists only when MAZE_GOAL_DETECT_EN is defined.
interface maze_position_datapath_if;
    logic moveUp, moveDown, moveLeft, moveRight, doneChangePosition, eraseBox, drawBox;
    logic doneErase, doneCheckLegal, doneDraw, isLegal;
    logic [5:0] cell_x;
    logic [4:0] cell_y;
    logic [10:0] maze_addr;
    logic maze_wall;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic vga_plot;
`ifdef MAZE_GOAL_DETECT_EN
    logic reachedGoal;
`endif
    modport master (
        output moveUp, moveDown, moveLeft, moveRight, doneChangePosition, eraseBox, drawBox, maze_wall,
        input doneErase, doneCheckLegal, doneDraw, isLegal, cell_x, cell_y, maze_addr,
        input vga_x, vga_y, vga_colour, vga_plot
`ifdef MAZE_GOAL_DETECT_EN
        , input reachedGoal
`endif
    );
    modport slave (
        input moveUp, moveDown, moveLeft, moveRight, doneChangePosition, eraseBox, drawBox, maze_wall,
        output doneErase, doneCheckLegal, doneDraw, isLegal, cell_x, cell_y, maze_addr,
        output vga_x, vga_y, vga_colour, vga_plot
`ifdef MAZE_GOAL_DETECT_EN
        , output reachedGoal
`endif
    );
endinterface

// File: rtl/box_sweeper.sv
// box_sweeper: px/py raster counter over one BOX x BOX player box, px fastest.
module box_sweeper #(
    parameter int BOX = 4,
    localparam int PW = (BOX > 1) ? $clog2(BOX) : 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clear,
    input  logic          start,
    output logic          busy,
    output logic          last,
    output logic [PW-1:0] px,
    output logic [PW-1:0] py
);
    assign last = busy && &px && &py;
    // BOX is a power of two, so the counters wrap back to (0,0) on the last pixel.
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            busy <= 1'b0;
            px   <= '0;
            py   <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            px   <= '0;
            py   <= '0;
        end else if (busy) begin
            px   <= px + 1'b1;
            py   <= &px ? py + 1'b1 : py;
            busy <= !last;
        end else if (start)
            busy <= 1'b1;
endmodule

// File: rtl/maze_position_datapath.sv
// maze_position_datapath: player cell tracking, move legality check against wall memory, and box erase/draw.
// Define MAZE_GOAL_DETECT_EN to add the sticky reachedGoal output that blocks further moves.
module maze_position_datapath
    import maze_pkg::*;
#(
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int BOX     = DEF_BOX,
    parameter int START_X = DEF_START_X,
    parameter int START_Y = DEF_START_Y,
    parameter int GOAL_X  = DEF_GOAL_X,
    parameter int GOAL_Y  = DEF_GOAL_Y,
    parameter logic [2:0] BG_COLOUR     = DEF_BG_COLOUR,
    parameter logic [2:0] PLAYER_COLOUR = DEF_PLAYER_COLOUR
) (
    input logic clock,
    input logic resetn,
    input logic externalReset,
    maze_position_datapath_if.slave bus
);
    localparam int PW = (BOX > 1) ? $clog2(BOX) : 1;
    state_t state, nxt;
    dir_t dir;
    logic dir_valid, start, busy, last, in_range, rd, legal, goal;
    logic done_erase, done_check, done_draw, is_legal;
    logic [PW-1:0] px, py;
    logic [5:0] cell_x, tx;
    logic [4:0] cell_y, ty;

    box_sweeper #(.BOX(BOX)) sweeper (
        .clock(clock), .resetn(resetn), .clear(externalReset), .start(start),
        .busy(busy), .last(last), .px(px), .py(py)
    );

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= externalReset ? IDLE : nxt;

    always_comb begin
        nxt   = state;
        start = 1'b0;
        case (state)
            IDLE: begin
                start = bus.eraseBox || bus.drawBox;
                nxt   = bus.eraseBox ? ERASE : bus.drawBox ? DRAW : IDLE;
            end
            ERASE:      nxt = last ? CHECK_ADDR : ERASE;
            CHECK_ADDR: nxt = CHECK_WAIT;
            CHECK_WAIT: nxt = CHECK_DONE;
            CHECK_DONE: nxt = IDLE;
            DRAW:       nxt = last ? IDLE : DRAW;
            default:    nxt = IDLE;
        endcase
    end

    // Edge cells are rejected before any arithmetic, so targets never wrap.
    always_comb begin
        in_range = dir == UP ? cell_y != 5'd0 : dir == DOWN ? cell_y != 5'(GRID_H - 1) :
                   dir == LEFT ? cell_x != 6'd0 : cell_x != 6'(GRID_W - 1);
        tx = dir == LEFT ? cell_x - 6'd1 : dir == RIGHT ? cell_x + 6'd1 : cell_x;
        ty = dir == UP ? cell_y - 5'd1 : dir == DOWN ? cell_y + 5'd1 : cell_y;
        rd = dir_valid && in_range;
        legal = rd && !bus.maze_wall && !goal;
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            cell_x     <= 6'(START_X);
            cell_y     <= 5'(START_Y);
            dir        <= UP;
            dir_valid  <= 1'b0;
            is_legal   <= 1'b0;
            done_erase <= 1'b0;
            done_check <= 1'b0;
            done_draw  <= 1'b0;
            goal       <= 1'b0;
        end else begin
            if (bus.doneChangePosition) begin
                dir       <= encode_dir(bus.moveUp, bus.moveDown, bus.moveLeft, bus.moveRight);
                dir_valid <= $onehot({bus.moveUp, bus.moveDown, bus.moveLeft, bus.moveRight});
            end
            done_erase <= state == ERASE && last;
            done_draw  <= state == DRAW && last;
            done_check <= state == CHECK_WAIT;
            if (state == CHECK_WAIT) begin
                is_legal <= legal;
                cell_x   <= legal ? tx : cell_x;
                cell_y   <= legal ? ty : cell_y;
`ifdef MAZE_GOAL_DETECT_EN
                goal     <= goal || (legal && tx == 6'(GOAL_X) && ty == 5'(GOAL_Y));
`endif
            end
            if (externalReset) begin
                cell_x     <= 6'(START_X);
                cell_y     <= 5'(START_Y);
                dir        <= UP;
                dir_valid  <= 1'b0;
                is_legal   <= 1'b0;
                done_erase <= 1'b0;
                done_check <= 1'b0;
                done_draw  <= 1'b0;
                goal       <= 1'b0;
            end
        end

    assign bus.maze_addr      = (state == CHECK_ADDR || state == CHECK_WAIT) && rd ? 11'(ty * GRID_W + tx) : '0;
    assign bus.vga_plot       = state == ERASE || state == DRAW;
    assign bus.vga_x          = bus.vga_plot ? 8'(cell_x * BOX) + 8'(px) : '0;
    assign bus.vga_y          = bus.vga_plot ? 7'(cell_y * BOX) + 7'(py) : '0;
    assign bus.vga_colour     = state == ERASE ? BG_COLOUR : state == DRAW ? PLAYER_COLOUR : 3'b000;
    assign bus.doneErase      = done_erase;
    assign bus.doneCheckLegal = done_check;
    assign bus.doneDraw       = done_draw;
    assign bus.isLegal        = is_legal;
    assign bus.cell_x         = cell_x;
    assign bus.cell_y         = cell_y;
`ifdef MAZE_GOAL_DETECT_EN
    assign bus.reachedGoal    = goal;
`endif
endmodule

// File: tb/tb_maze_position_datapath.sv
// tb_maze_position_datapath: table-driven move checks with a pixel scoreboard, plus reset and sweep-abort sequences.
module tb_maze_position_datapath;
    import maze_pkg::*;
    typedef struct {
        logic [3:0]  mv;
        logic        wall;
        logic        rd;
        logic [10:0] addr;
        logic        legal;
        logic [5:0]  cx;
        logic [4:0]  cy;
    } vec_t;
    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clock = 1'b0, resetn = 1'b0, ext_rst = 1'b0;
    maze_position_datapath_if bus();
    maze_position_datapath dut (.clock(clock), .resetn(resetn), .externalReset(ext_rst), .bus(bus));
    always #5 clock = ~clock;

    pix_t exp_q[$];
    pix_t mon_p;
    int errors = 0, checks = 0, cyc = 0, last_plot = -100, addr_cnt = 0, done_draw_cnt = 0;
    int mx = 1, my = 1;
    logic [10:0] last_addr = '0;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        cyc++;
        if (bus.maze_addr != '0) begin
            addr_cnt++;
            last_addr = bus.maze_addr;
        end
        if (bus.doneDraw) done_draw_cnt++;
        if (bus.vga_plot) begin
            last_plot = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d with empty scoreboard", bus.vga_x, bus.vga_y, bus.vga_colour);
            end else begin
                mon_p = exp_q.pop_front();
                check($sformatf("plot x=%0d y=%0d c=%0d", mon_p.x, mon_p.y, mon_p.c),
                      {14'd0, bus.vga_x, bus.vga_y, bus.vga_colour}, {14'd0, mon_p.x, mon_p.y, mon_p.c});
            end
        end
    end

    task automatic push_box(input int x, input int y, input logic [2:0] c);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++) exp_q.push_back('{8'(x * 4 + i), 7'(y * 4 + j), c});
    endtask

    task automatic wait_done(input string name, input int sel);
        int n = 0;
        while (!(sel == 0 ? bus.doneErase : bus.doneDraw) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_in_time"}, n < 200, 1);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        {bus.moveUp, bus.moveDown, bus.moveLeft, bus.moveRight} = v.mv;
        bus.doneChangePosition = 1'b1;
        bus.maze_wall = v.wall;
        tick();
        bus.doneChangePosition = 1'b0;
        {bus.moveUp, bus.moveDown, bus.moveLeft, bus.moveRight} = 4'b0;
        addr_cnt = 0;
        push_box(mx, my, 3'b111);
        bus.eraseBox = 1'b1;
        wait_done($sformatf("v%0d_erase", k), 0);
        bus.eraseBox = 1'b0;
        check($sformatf("v%0d_erase_pixels_left", k), exp_q.size(), 0);
        check($sformatf("v%0d_doneErase_gap", k), cyc - last_plot, 1);
        tick();
        check($sformatf("v%0d_doneCheckLegal_early", k), bus.doneCheckLegal, 0);
        tick();
        check($sformatf("v%0d_doneCheckLegal", k), bus.doneCheckLegal, 1);
        check($sformatf("v%0d_isLegal", k), bus.isLegal, v.legal);
        check($sformatf("v%0d_cell_x", k), bus.cell_x, v.cx);
        check($sformatf("v%0d_cell_y", k), bus.cell_y, v.cy);
        check($sformatf("v%0d_addr_cycles", k), addr_cnt, v.rd ? 2 : 0);
        if (v.rd) check($sformatf("v%0d_maze_addr", k), last_addr, v.addr);
        mx = v.cx;
        my = v.cy;
        push_box(mx, my, 3'b100);
        bus.drawBox = 1'b1;
        wait_done($sformatf("v%0d_draw", k), 1);
        bus.drawBox = 1'b0;
        check($sformatf("v%0d_draw_pixels_left", k), exp_q.size(), 0);
        check($sformatf("v%0d_doneDraw_gap", k), cyc - last_plot, 1);
        tick();
    endtask

    initial begin
        // mv = {up, down, left, right}
        vt = '{
            '{4'b0001, 1'b0, 1'b1, 11'd42, 1'b1, 6'd2, 5'd1},
            '{4'b0010, 1'b0, 1'b1, 11'd41, 1'b1, 6'd1, 5'd1},
            '{4'b0100, 1'b1, 1'b1, 11'd81, 1'b0, 6'd1, 5'd1},
            '{4'b1000, 1'b0, 1'b1, 11'd1,  1'b1, 6'd1, 5'd0},
            '{4'b1000, 1'b0, 1'b0, 11'd0,  1'b0, 6'd1, 5'd0},
            '{4'b1010, 1'b0, 1'b0, 11'd0,  1'b0, 6'd1, 5'd0},
            '{4'b0000, 1'b0, 1'b0, 11'd0,  1'b0, 6'd1, 5'd0},
            '{4'b0001, 1'b1, 1'b1, 11'd2,  1'b0, 6'd1, 5'd0},
            '{4'b0100, 1'b0, 1'b1, 11'd41, 1'b1, 6'd1, 5'd1},
            '{4'b0001, 1'b0, 1'b1, 11'd42, 1'b1, 6'd2, 5'd1}
        };
        {bus.moveUp, bus.moveDown, bus.moveLeft, bus.moveRight} = 4'b0;
        bus.doneChangePosition = 1'b0;
        bus.eraseBox = 1'b0;
        bus.drawBox = 1'b0;
        bus.maze_wall = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (10) tick();
        check("reset_cell_x", bus.cell_x, 1);
        check("reset_cell_y", bus.cell_y, 1);
        check("reset_outputs", {bus.vga_plot, bus.doneErase, bus.doneCheckLegal, bus.doneDraw, bus.isLegal}, 0);
        check("reset_maze_addr", bus.maze_addr, 0);
        for (int k = 0; k < 10; k++) run_vec(vt[k], k);

        // abort a draw at (2,1) after five pixels with the synchronous game reset
        push_box(mx, my, 3'b100);
        bus.drawBox = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() > 11; n++) tick();
        check("abort_pixels_before_reset", exp_q.size(), 11);
        done_draw_cnt = 0;
        ext_rst = 1'b1;
        bus.drawBox = 1'b0;
        tick();
        ext_rst = 1'b0;
        check("abort_vga_plot", bus.vga_plot, 0);
        check("abort_pixels_after_reset", exp_q.size(), 11);
        exp_q.delete();
        repeat (5) tick();
        check("abort_no_doneDraw", done_draw_cnt, 0);
        check("abort_cell_x", bus.cell_x, 1);
        check("abort_cell_y", bus.cell_y, 1);
        check("abort_isLegal", bus.isLegal, 0);
        mx = 1;
        my = 1;
        run_vec(vt[0], 10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
